button_debouncer: RTL and testbench

Front-end conditioning stage for raw push-button inputs such as S1. It synchronises the asynchronous pad signal into the clk domain and filters out contact bounce. It then drives a clean level plus single-cycle edge pulses into the downstream 6-second register/counter FSM, which samples its S1 input every cycle and must never see bounce or metastable values.

---
 rtl/button_debouncer_pkg.sv | 20 ++
 rtl/button_debouncer_if.sv | 19 +
 rtl/button_debouncer_sync.sv | 29 ++
 rtl/button_debouncer.sv | 105 ++++++++++
 tb/tb_button_debouncer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared state encoding and clock constants for push-button debouncing.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  localparam int CLK_HZ                = 50000000;
  localparam int DEFAULT_STABLE_CYCLES = 300000;

endpackage
`default_nettype wire

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer_if
// Purpose  : Raw pad input and conditioned level/edge outputs of a debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface button_debouncer_if;

  logic btn_raw;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  // master: pad/consumer side; slave: debouncer side
  modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall);
  modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall);

endinterface
`default_nettype wire

// File: rtl/button_debouncer_sync.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Multi-flop synchroniser bringing an asynchronous pad into clk.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Purpose  : Synchronise and debounce a push-button; clean level plus edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  button_debouncer_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic             w_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_raw),
    .q     (w_s)
  );

  // Any disagreeing sample drops back to the idle state, so every bounce restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= CHECK_HIGH;
            r_cnt   <= c_CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= IDLE_HIGH;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + c_CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= CHECK_LOW;
            r_cnt   <= c_CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        CHECK_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == c_CNT_LAST) begin
            r_state <= IDLE_LOW;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level = r_level;
  assign bus.btn_rise  = r_rise;
  assign bus.btn_fall  = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Purpose  : Directed self-checking bench for button_debouncer (STABLE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  button_debouncer_if bif ();

  button_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges; rise_at/fall_at give the 1-based edge of the expected pulse (0 = none).
  task automatic run_edges(input string name, input int n, input int rise_at,
                           input int fall_at, input logic lvl_before);
    logic exp_lvl;
    for (int k = 1; k <= n; k++) begin
      tick();
      exp_lvl = lvl_before;
      if (rise_at > 0 && k >= rise_at) exp_lvl = 1'b1;
      if (fall_at > 0 && k >= fall_at) exp_lvl = 1'b0;
      chk($sformatf("%s_lvl_e%0d", name, k), 32'(bif.btn_level), 32'(exp_lvl));
      chk($sformatf("%s_rise_e%0d", name, k), 32'(bif.btn_rise), 32'(k == rise_at));
      chk($sformatf("%s_fall_e%0d", name, k), 32'(bif.btn_fall), 32'(k == fall_at));
    end
  endtask

  initial begin
    logic bounce [6];
    logic prev_lvl;
    int   rises;
    int   falls;
    int   spurious;

    n_total     = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bif.btn_raw = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(bif.btn_level), 32'd0);
    chk("rst_rise",  32'(bif.btn_rise),  32'd0);
    chk("rst_fall",  32'(bif.btn_fall),  32'd0);

    // 1: press held from edge 1 -> rise at edge 6
    @(negedge clk);
    rst_n       = 1'b1;
    bif.btn_raw = 1'b1;
    run_edges("press", 8, 6, 0, 1'b0);

    // 2: 3-cycle low glitch while pressed is rejected
    bif.btn_raw = 1'b0;
    run_edges("glitch_lo", 3, 0, 0, 1'b1);
    bif.btn_raw = 1'b1;
    run_edges("glitch_rec", 6, 0, 0, 1'b1);

    // 4: release -> fall 6 edges after the change
    bif.btn_raw = 1'b0;
    run_edges("release", 8, 0, 6, 1'b1);
    run_edges("settle", 2, 0, 0, 1'b0);

    // 3: bounce burst 1,0,1,1,0,1 then steady 1 -> single rise at edge 11
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bif.btn_raw = bounce[i];
      tick();
      chk($sformatf("bounce_lvl_e%0d", i + 1), 32'(bif.btn_level), 32'd0);
      chk($sformatf("bounce_rise_e%0d", i + 1), 32'(bif.btn_rise), 32'd0);
    end
    run_edges("bounce_tail", 7, 5, 0, 1'b0);

    bif.btn_raw = 1'b0;
    run_edges("release2", 8, 0, 6, 1'b1);

    // 5: async reset in CHECK_HIGH with cnt=2, button kept pressed
    bif.btn_raw = 1'b1;
    run_edges("pre_rst", 4, 0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(bif.btn_level), 32'd0);
    chk("midrst_rise",  32'(bif.btn_rise),  32'd0);
    chk("midrst_fall",  32'(bif.btn_fall),  32'd0);
    tick();
    chk("midrst_hold_level", 32'(bif.btn_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("post_rst", 8, 6, 0, 1'b0);

    // Reset while pressed drops the level with no fall pulse
    #2;
    rst_n = 1'b0;
    #1;
    chk("hirst_level", 32'(bif.btn_level), 32'd0);
    chk("hirst_fall",  32'(bif.btn_fall),  32'd0);
    bif.btn_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("hirst_after", 8, 0, 0, 1'b0);

    // 6: press/release/press, 10 cycles each, observed as a downstream S1 consumer
    rises    = 0;
    falls    = 0;
    spurious = 0;
    prev_lvl = bif.btn_level;
    for (int p = 0; p < 3; p++) begin
      bif.btn_raw = (p != 1);
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bif.btn_level && !prev_lvl) rises++;
        if (!bif.btn_level && prev_lvl) falls++;
        if (bif.btn_rise !== (bif.btn_level && !prev_lvl)) spurious++;
        if (bif.btn_fall !== (!bif.btn_level && prev_lvl)) spurious++;
        prev_lvl = bif.btn_level;
      end
    end
    chk("seq_rises",    32'(rises),    32'd2);
    chk("seq_falls",    32'(falls),    32'd1);
    chk("seq_spurious", 32'(spurious), 32'd0);
    chk("seq_final",    32'(bif.btn_level), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
